cyclic_prefix_inserter: RTL
===========================

# cyclic_prefix_inserter

Downstream neighbour of the inverse FFT in the LTE transmit chain: consumes one time-domain OFDM symbol (N complex samples) per Avalon-ST packet, buffers it, and re-emits it prefixed by a copy of its last CP samples. CP length follows the LTE normal-CP slot pattern: the first symbol of a slot gets a longer prefix. Output feeds the framing/DAC interface stage.

## Interface
- N, 128: IFFT size, samples per input packet.
- DATA_W, 32: width of each of real/imag.
- CP_FIRST, 10: CP length for symbol 0 of a slot.
- CP_OTHER, 9: CP length for symbols 1..SYMS-1.
- SYMS, 7: symbols per slot.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sink_valid  in  1  input sample valid.
- sink_ready  out  1  block can accept an input sample.
- sink_error  in  2  per-sample error from IFFT.
- sink_sop  in  1  first sample of symbol.
- sink_eop  in  1  last sample of symbol.
- sink_real, sink_imag  in  DATA_W  input sample.
- source_valid  out  1  output sample valid.
- source_ready  in  1  downstream accepts (ready latency 0).
- source_error  out  2  OR of sink_error over the symbol, held on every output sample of it.
- source_sop, source_eop  out  1  first CP sample / last body sample.
- source_real, source_imag  out  DATA_W  output sample.
- sym_idx  out  3  index of symbol currently being emitted (0..SYMS-1).
- frame_dropped  out  1  one-cycle pulse when a malformed input packet is discarded.

## Operation
- Single N-entry buffer (register array, combinational read). States FILL, EMIT_CP, EMIT_BODY.
- FILL: sink_ready=1. Transfer = sink_valid&sink_ready. Write sample at wr_cnt, wr_cnt++, err_acc |= sink_error.
  - Transfer with sink_sop: written at address 0, wr_cnt=1, err_acc=sink_error (restart; if wr_cnt was nonzero, pulse frame_dropped).
  - Transfer without sop while wr_cnt==0: ignored, frame_dropped pulsed.
  - Transfer with sink_eop at wr_cnt!=N-1, or no eop at wr_cnt==N-1: discard, wr_cnt=0, frame_dropped pulsed, sym_idx unchanged.
  - Transfer with eop at wr_cnt==N-1: write, latch cp_len = (sym_idx==0)?CP_FIRST:CP_OTHER, rd_cnt=0, go EMIT_CP.
- EMIT_CP: sink_ready=0, source_valid=1, data = buf[N-cp_len+rd_cnt], source_sop=(rd_cnt==0). On source_ready: rd_cnt++; at rd_cnt==cp_len-1 go EMIT_BODY with rd_cnt=0.
- EMIT_BODY: source_valid=1, data = buf[rd_cnt], source_eop=(rd_cnt==N-1). On source_ready at N-1: sym_idx = (sym_idx==SYMS-1)?0:sym_idx+1, wr_cnt=0, err_acc=0, go FILL.
- source_error = err_acc latched at eop, constant across emitted packet; 0 in FILL.
- Output packet length N+cp_len (138 or 137 at defaults); sop and eop never on same sample.

## Timing
- Reset values: state=FILL, sink_ready=1 on first cycle after reset, source_valid=0, source_sop/eop=0, source_error=0, source_real/imag=0, sym_idx=0, frame_dropped=0, counters 0.
- Latency: first CP sample valid the cycle after the eop transfer.
- Output holds data/sop/eop stable while source_valid&!source_ready.
- Minimum period per symbol: N input cycles + N+cp_len output cycles (no overlap; sink_ready low throughout emission).
- sink_ready is a pure function of state (no dependence on sink_valid).
- Reset asserted mid-fill or mid-emission: next cycle in FILL, partial symbol lost, no frame_dropped pulse, sym_idx=0.
- sym_idx wraps 6->0; output reflects symbol being emitted, updates on final body transfer.

## Test plan
- Reset, feed 7 ramp symbols (real=k, imag=-k, k=0..127), source_ready=1 -> symbol 0: 138 samples, first = real 118..127 then 0..127; symbols 1..6: 137 samples starting real 119; sym_idx 0..6 then wraps to 0 on 8th.
- Random source_ready toggling (50%) during emission -> output sequence identical to ready=1 case, data stable while stalled, sink_ready=0 throughout.
- Packet with eop at sample 63 -> frame_dropped pulse once, no output, next valid 128-sample packet emitted with CP_FIRST=10, sym_idx still 0.
- sink_error=2'b01 on sample 40 only -> every output sample of that symbol has source_error=01; next clean symbol shows 00.
- New sop at sample 50 of a packet -> frame_dropped pulse, restart at address 0; subsequent 128 samples emitted normally.
- Assert reset on 20th CP/body output cycle -> next cycle source_valid=0, sink_ready=1, sym_idx=0; next symbol emitted with 10-sample CP.

Source files
------------

// File: rtl/cyclic_prefix_inserter.sv
// rtl/cyclic_prefix_inserter.sv - buffers one OFDM symbol and re-emits it behind a cyclic prefix
// Slot-aware CP length: symbol 0 of each slot gets CP_FIRST, the rest CP_OTHER.
module cyclic_prefix_inserter #(
    parameter int N        = 128,
    parameter int DATA_W   = 32,
    parameter int CP_FIRST = 10,
    parameter int CP_OTHER = 9,
    parameter int SYMS     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic [1:0]        sink_error,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [DATA_W-1:0] sink_real,
    input  logic [DATA_W-1:0] sink_imag,
    output logic              source_valid,
    input  logic              source_ready,
    output logic [1:0]        source_error,
    output logic              source_sop,
    output logic              source_eop,
    output logic [DATA_W-1:0] source_real,
    output logic [DATA_W-1:0] source_imag,
    output logic [2:0]        sym_idx,
    output logic              frame_dropped
);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CP_FIRST_L = CNT_W'(CP_FIRST);
    localparam logic [CNT_W-1:0] CP_OTHER_L = CNT_W'(CP_OTHER);
    localparam logic [CNT_W-1:0] N_MOD      = CNT_W'(N);
    localparam logic [2:0]       SYM_LAST   = 3'(SYMS - 1);

    typedef enum logic [1:0] {FILL, EMIT_CP, EMIT_BODY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    cp_len_q, cp_len_d;
    logic [1:0]          err_acc_q, err_acc_d;
    logic [2:0]          sym_q, sym_d;
    logic                drop_q, drop_d;
    logic [2*DATA_W-1:0] mem_q [N];

    logic             wr_en;
    logic [CNT_W-1:0] wr_addr;
    logic [CNT_W-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            cp_len_q  <= '0;
            err_acc_q <= '0;
            sym_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            cp_len_q  <= cp_len_d;
            err_acc_q <= err_acc_d;
            sym_q     <= sym_d;
            drop_q    <= drop_d;
        end
    end

    // Sample storage carries no reset; outputs are gated to zero outside emission.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {sink_real, sink_imag};
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        cp_len_d     = cp_len_q;
        err_acc_d    = err_acc_q;
        sym_d        = sym_q;
        drop_d       = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = wr_cnt_q;
        rd_addr      = rd_cnt_q;
        sink_ready   = 1'b0;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;

        unique case (state_q)
            FILL: begin
                sink_ready = 1'b1;
                if (sink_valid) begin
                    if (sink_sop) begin
                        if (sink_eop) begin
                            // one-sample packet can never be a whole symbol
                            drop_d    = 1'b1;
                            wr_cnt_d  = '0;
                            err_acc_d = '0;
                        end else begin
                            drop_d    = (wr_cnt_q != '0);
                            wr_en     = 1'b1;
                            wr_addr   = '0;
                            wr_cnt_d  = CNT_W'(1);
                            err_acc_d = sink_error;
                        end
                    end else if (wr_cnt_q == '0) begin
                        drop_d = 1'b1;
                    end else if (sink_eop != (wr_cnt_q == LAST)) begin
                        drop_d    = 1'b1;
                        wr_cnt_d  = '0;
                        err_acc_d = '0;
                    end else if (sink_eop) begin
                        wr_en     = 1'b1;
                        err_acc_d = err_acc_q | sink_error;
                        cp_len_d  = (sym_q == 3'd0) ? CP_FIRST_L : CP_OTHER_L;
                        rd_cnt_d  = '0;
                        state_d   = EMIT_CP;
                    end else begin
                        wr_en     = 1'b1;
                        wr_cnt_d  = wr_cnt_q + 1'b1;
                        err_acc_d = err_acc_q | sink_error;
                    end
                end
            end
            EMIT_CP: begin
                source_valid = 1'b1;
                source_sop   = (rd_cnt_q == '0);
                // modular address arithmetic: N wraps to 0 in CNT_W bits
                rd_addr      = N_MOD - cp_len_q + rd_cnt_q;
                if (source_ready) begin
                    if (rd_cnt_q == cp_len_q - 1'b1) begin
                        rd_cnt_d = '0;
                        state_d  = EMIT_BODY;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            EMIT_BODY: begin
                source_valid = 1'b1;
                source_eop   = (rd_cnt_q == LAST);
                if (source_ready) begin
                    if (rd_cnt_q == LAST) begin
                        sym_d     = (sym_q == SYM_LAST) ? 3'd0 : sym_q + 3'd1;
                        wr_cnt_d  = '0;
                        err_acc_d = '0;
                        rd_cnt_d  = '0;
                        state_d   = FILL;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        {source_real, source_imag} = '0;
        source_error               = 2'b00;
        if (source_valid) begin
            {source_real, source_imag} = mem_q[rd_addr];
            source_error               = err_acc_q;
        end
    end

    assign sym_idx       = sym_q;
    assign frame_dropped = drop_q;

endmodule
